// File: rtl/bf_exec_unit.sv
// bf_exec_unit: Brainfuck execute stage with run-length ops, BRNZ, I/O handshakes, write-back bypass and HALT.
// Optional build macro BF_EXEC_SAT_EN: PLUS/MINUS saturate instead of wrapping.
module bf_exec_unit #(
    parameter int DATA_W = 16,
    parameter int PTR_W = 16,
    parameter logic [PTR_W-1:0] PTR_RESET = PTR_W'(128)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ins_in,
    input  logic              ins_valid,
    output logic              stall,
    input  logic [DATA_W-1:0] val_in,
    output logic [DATA_W-1:0] val_out,
    output logic              wb_en,
    output logic [PTR_W-1:0]  ptr_select,
    output logic [PTR_W-1:0]  ptr_wb,
    output logic [15:0]       branch_val,
    output logic              branch_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state_q;
    logic [15:0] ins_q;
    logic [DATA_W-1:0] val_q, n_dat, plus_v, minus_v;
    logic [PTR_W-1:0] ptr_q, n_ptr, nptr;
    logic [11:0] n12;
    logic [3:0] op;
    logic take;
    assign op = ins_q[15:12];
    assign n12 = (ins_q[11:0] == 12'd0) ? 12'd1 : ins_q[11:0];
    assign n_dat = DATA_W'(n12);
    assign n_ptr = PTR_W'(n12);
`ifdef BF_EXEC_SAT_EN
    logic [DATA_W:0] sum, diff;
    assign sum = {1'b0, val_q} + {1'b0, n_dat};
    assign diff = {1'b0, val_q} - {1'b0, n_dat};
    assign plus_v = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    assign minus_v = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
    assign plus_v = val_q + n_dat;
    assign minus_v = val_q - n_dat;
`endif
    assign ptr_select = nptr;
    assign ptr_wb = ptr_q;
    assign out_data = val_q;
    assign halted = (state_q == HALT);
    assign branch_val = branch_en ? {4'h0, ins_q[11:0]} : 16'h0000;
    // Decode the held instruction into next pointer, write-back, branch, handshake and stall.
    always_comb begin
        nptr = ptr_q;
        val_out = val_q;
        wb_en = 1'b0;
        take = 1'b0;
        out_valid = 1'b0;
        in_ready = 1'b0;
        stall = halted;
        if (!halted) begin
            case (op)
                4'h1: begin val_out = plus_v; wb_en = 1'b1; end
                4'h2: begin val_out = minus_v; wb_en = 1'b1; end
                4'h3: nptr = ptr_q + n_ptr;
                4'h4: nptr = ptr_q - n_ptr;
                4'h5: take = (val_q == '0);
                4'h6: take = 1'b1;
                4'h7: take = (val_q != '0);
                4'h9: begin out_valid = 1'b1; stall = !out_ready; end
                4'hA: begin
                    in_ready = 1'b1;
                    val_out = in_valid ? in_data : val_q;
                    wb_en = in_valid;
                    stall = !in_valid;
                end
                default: ;
            endcase
        end
        branch_en = take;
    end
    // Retire on every non-stalled edge; the val bypass covers a tape write that has not landed yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_q <= 16'h0000;
            val_q <= '0;
            ptr_q <= PTR_RESET;
            state_q <= RUN;
        end else if (!stall) begin
            ins_q <= ins_valid ? ins_in : 16'h0000;
            ptr_q <= nptr;
            val_q <= wb_en ? val_out : val_in;
            if (op == 4'hF) state_q <= HALT;
        end
    end
endmodule

// File: tb/tb_bf_exec_unit.sv
// tb_bf_exec_unit: directed vectors with hand-computed expectations for bf_exec_unit.
module tb_bf_exec_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] ins_in = '0, branch_val;
    logic ins_valid = 1'b0, stall, wb_en, branch_en, out_valid, out_ready = 1'b0;
    logic in_valid = 1'b0, in_ready, halted;
    logic [15:0] val_in = '0, val_out, out_data, in_data = '0, ptr_select, ptr_wb;
    int n_chk = 0, n_fail = 0, xfers = 0;
    logic [15:0] last_print = '0;
    bf_exec_unit dut (
        .clk(clk), .rst(rst), .ins_in(ins_in), .ins_valid(ins_valid), .stall(stall),
        .val_in(val_in), .val_out(val_out), .wb_en(wb_en), .ptr_select(ptr_select),
        .ptr_wb(ptr_wb), .branch_val(branch_val), .branch_en(branch_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .halted(halted)
    );
    always #5 clk = ~clk;
    // Count accepted print transfers mid-cycle, away from the active edge.
    always @(negedge clk) if (out_valid && out_ready) begin xfers++; last_print = out_data; end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [15:0] ins, input logic [15:0] val);
        ins_in = ins;
        ins_valid = 1'b1;
        val_in = val;
        tick();
        ins_in = '0;
        ins_valid = 1'b0;
        val_in = '0;
    endtask
    initial begin
        tick(); tick();
        check("rst_stall", stall, 0);
        check("rst_wb", wb_en, 0);
        check("rst_psel", ptr_select, 128);
        check("rst_pwb", ptr_wb, 128);
        check("rst_vout", val_out, 0);
        check("rst_halt", halted, 0);
        check("rst_oval", out_valid, 0);
        check("rst_irdy", in_ready, 0);
        @(negedge clk) rst = 1'b0;
        // T1: run-length PLUS then legacy PLUS through the bypass
        issue(16'h1003, 16'h0000);
        check("t1_wb1", wb_en, 1);
        check("t1_v1", val_out, 3);
        check("t1_pwb", ptr_wb, 128);
        issue(16'h1000, 16'h0000);
        check("t1_wb2", wb_en, 1);
        check("t1_v2", val_out, 4);
        tick();
        check("t1_nop_wb", wb_en, 0);
        // T2: pointer wrap both directions
        issue(16'h4082, 16'h0000);
        check("t2_dec", ptr_select, 16'hFFFE);
        issue(16'h3002, 16'h0000);
        check("t2_pwb", ptr_wb, 16'hFFFE);
        check("t2_inc", ptr_select, 0);
        // T3: branches
        issue(16'h5020, 16'h0000);
        check("t3_brz_en", branch_en, 1);
        check("t3_brz_val", branch_val, 16'h0020);
        issue(16'h7020, 16'h0000);
        check("t3_brnz_en", branch_en, 0);
        check("t3_brnz_val", branch_val, 0);
        issue(16'h6123, 16'h0009);
        check("t3_br_val", branch_val, 16'h0123);
        issue(16'h7045, 16'h0009);
        check("t3_brnz1_en", branch_en, 1);
        check("t3_brnz1_val", branch_val, 16'h0045);
        tick();
        // T4: PRINT with back-pressure
        issue(16'h9000, 16'h0005);
        check("t4_ov1", out_valid, 1);
        check("t4_od", out_data, 5);
        check("t4_st1", stall, 1);
        tick();
        check("t4_st2", stall, 1);
        tick();
        check("t4_st3", stall, 1);
        check("t4_ov3", out_valid, 1);
        tick();
        out_ready = 1'b1;
        #1;
        check("t4_ov4", out_valid, 1);
        check("t4_st4", stall, 0);
        tick();
        out_ready = 1'b0;
        check("t4_ov_after", out_valid, 0);
        check("t4_xfers", xfers, 1);
        check("t4_data", last_print, 5);
        // T5: READ with delayed input, then reset mid-wait
        issue(16'hA000, 16'h0000);
        check("t5_ir", in_ready, 1);
        check("t5_st1", stall, 1);
        check("t5_wb0", wb_en, 0);
        tick();
        check("t5_st2", stall, 1);
        tick();
        in_valid = 1'b1;
        in_data = 16'h0007;
        #1;
        check("t5_st3", stall, 0);
        check("t5_wb", wb_en, 1);
        check("t5_v", val_out, 7);
        tick();
        in_valid = 1'b0;
        issue(16'hA000, 16'h0000);
        tick();
        check("t5_ir2", in_ready, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_ir", in_ready, 0);
        check("t5_rst_st", stall, 0);
        check("t5_rst_pwb", ptr_wb, 128);
        @(negedge clk) rst = 1'b0;
        // T6: overflow boundary, underflow boundary, HALT
        issue(16'h1001, 16'hFFFF);
`ifdef BF_EXEC_SAT_EN
        check("t6_plus_max", val_out, 16'hFFFF);
`else
        check("t6_plus_max", val_out, 16'h0000);
`endif
        tick();
        issue(16'h2005, 16'h0003);
`ifdef BF_EXEC_SAT_EN
        check("t6_minus_min", val_out, 16'h0000);
`else
        check("t6_minus_min", val_out, 16'hFFFE);
`endif
        tick();
        issue(16'hF000, 16'h0000);
        check("t6_h0", halted, 0);
        check("t6_hst0", stall, 0);
        ins_in = 16'h1001;
        ins_valid = 1'b1;
        tick();
        check("t6_h1", halted, 1);
        check("t6_hst1", stall, 1);
        tick(); tick();
        check("t6_h3", halted, 1);
        check("t6_hst3", stall, 1);
        check("t6_hwb", wb_en, 0);
        ins_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_h", halted, 0);
        check("t6_rst_st", stall, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
